// File: rtl/conv_div_32s_16u_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_div_32s_16u_seq_if
// Brief    : Operand/result handshake bundle for the 32s/16u sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_div_32s_16u_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [16:0] remainder;
    logic        ovf;
    logic        dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );
endinterface
`default_nettype wire

// File: rtl/conv_div_32s_16u_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_div_32s_16u_seq
// Brief    : Signed 32-bit by unsigned 16-bit restoring divider, one quotient
//            bit per cycle, saturating 16-bit signed quotient, fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module conv_div_32s_16u_seq #(
    parameter int LATENCY = 34
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    conv_div_32s_16u_seq_if.slave        bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Accept and FIX cycles surround the iterations, leaving LATENCY-2 of them.
    localparam logic [4:0] c_CALC_LAST = 5'(LATENCY - 3);

    logic [1:0]  state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [31:0] dividend_q,  dividend_d;
    logic [15:0] divisor_q,   divisor_d;
    logic        sign_q,      sign_d;
    logic [31:0] mag_q,       mag_d;
    logic [15:0] rem_q,       rem_d;
    logic [15:0] quotient_q,  quotient_d;
    logic [16:0] remainder_q, remainder_d;
    logic        ovf_q,       ovf_d;
    logic        dz_q,        dz_d;

    logic [31:0] abs_dividend;
    logic [16:0] trial;
    logic        trial_ge;
    logic [15:0] trial_diff;
    logic [15:0] fix_quotient;
    logic [16:0] fix_remainder;
    logic        fix_ovf;

    assign bus.in_ready  = (state_q == c_IDLE);
    assign bus.out_valid = (state_q == c_DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;

    // Magnitude of the dividend; -2^31 maps cleanly onto 2^31 in 32 unsigned bits.
    assign abs_dividend = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;

    // The dividend magnitude shifts out MSB-first while quotient bits shift in.
    assign trial      = {rem_q, mag_q[31]};
    assign trial_ge   = (trial >= {1'b0, divisor_q});
    assign trial_diff = trial[15:0] - divisor_q;

    always_comb begin
        fix_quotient  = 16'h0000;
        fix_remainder = 17'h00000;
        fix_ovf       = 1'b0;
        if (divisor_q == 16'h0000) begin
            if (sign_q) begin
                fix_quotient = 16'h8000;
            end else if (dividend_q != 32'h0000_0000) begin
                fix_quotient = 16'h7FFF;
            end
        end else if (!sign_q) begin
            fix_ovf       = (mag_q > 32'd32767);
            fix_quotient  = fix_ovf ? 16'h7FFF : mag_q[15:0];
            fix_remainder = {1'b0, rem_q};
        end else begin
            // A negative result may reach -32768 before it saturates.
            fix_ovf       = (mag_q > 32'd32768);
            fix_quotient  = fix_ovf ? 16'h8000 : (~mag_q[15:0] + 16'd1);
            fix_remainder = ~{1'b0, rem_q} + 17'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;

        case (state_q)
            c_IDLE: begin
                if (bus.in_valid) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    sign_d     = bus.dividend[31];
                    mag_d      = abs_dividend;
                    rem_d      = 16'h0000;
                    cnt_d      = 5'd0;
                    state_d    = c_CALC;
                end
            end
            c_CALC: begin
                mag_d = {mag_q[30:0], trial_ge};
                rem_d = trial_ge ? trial_diff : trial[15:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_CALC_LAST) begin
                    state_d = c_FIX;
                end
            end
            c_FIX: begin
                quotient_d  = fix_quotient;
                remainder_d = fix_remainder;
                ovf_d       = fix_ovf;
                dz_d        = (divisor_q == 16'h0000);
                state_d     = c_DONE;
            end
            c_DONE: begin
                if (bus.out_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= c_IDLE;
            cnt_q       <= 5'd0;
            dividend_q  <= 32'h0000_0000;
            divisor_q   <= 16'h0000;
            sign_q      <= 1'b0;
            mag_q       <= 32'h0000_0000;
            rem_q       <= 16'h0000;
            quotient_q  <= 16'h0000;
            remainder_q <= 17'h00000;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_div_32s_16u_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_div_32s_16u_seq
// Brief    : Self-checking bench for conv_div_32s_16u_seq against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_div_32s_16u_seq;

    logic ap_clk;
    logic ap_rst_n;
    int   checks;
    int   failures;

    conv_div_32s_16u_seq_if bus ();

    conv_div_32s_16u_seq #(.LATENCY(34)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Integer division truncating toward zero, then saturation / zero-divisor rules.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [16:0] r,
                                  output logic o, output logic z);
        longint sa, sb, qt, rt;
        sa = $signed(a);
        sb = longint'(b);
        if (sb == 0) begin
            z = 1'b1;
            o = 1'b0;
            r = 17'h0;
            q = (sa > 0) ? 16'h7FFF : ((sa < 0) ? 16'h8000 : 16'h0000);
        end else begin
            z  = 1'b0;
            qt = sa / sb;
            rt = sa - qt * sb;
            r  = rt[16:0];
            if (qt > 32767) begin
                q = 16'h7FFF;
                o = 1'b1;
            end else if (qt < -32768) begin
                q = 16'h8000;
                o = 1'b1;
            end else begin
                q = qt[15:0];
                o = 1'b0;
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input string tag);
        logic [15:0] eq;
        logic [16:0] er;
        logic        eo, ez;
        int          lat;
        int          w;
        model(a, b, eq, er, eo, ez);
        @(negedge ap_clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge ap_clk);
            w++;
        end
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge ap_clk);
            #1;
            lat++;
            if (lat == 10) begin
                bus.dividend = $urandom;
                bus.divisor  = 16'($urandom);
            end
        end
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=34", tag, lat);
        end
        checks++;
        if (bus.quotient !== eq) begin
            failures++;
            $display("FAIL %s quotient a=%h b=%h got=%h exp=%h", tag, a, b, bus.quotient, eq);
        end
        checks++;
        if (bus.remainder !== er) begin
            failures++;
            $display("FAIL %s remainder a=%h b=%h got=%h exp=%h", tag, a, b, bus.remainder, er);
        end
        checks++;
        if ({bus.ovf, bus.dz} !== {eo, ez}) begin
            failures++;
            $display("FAIL %s flags a=%h b=%h got ovf=%b dz=%b exp ovf=%b dz=%b",
                     tag, a, b, bus.ovf, bus.dz, eo, ez);
        end
        @(negedge ap_clk);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL %s release got in_ready=%b out_valid=%b exp 1 0",
                     tag, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #3;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz}
            !== {1'b1, 1'b0, 16'h0, 17'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h ovf=%b dz=%b",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dz);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(32'd1000,               16'd7,     "d_1000_7");
        run_op(-32'sd1000,             16'd7,     "d_m1000_7");
        run_op(32'h7FFF_FFFF,          16'd1,     "d_max_1");
        run_op(32'h8000_0000,          16'd65535, "d_min_65535");
        run_op(32'h8000_0000,          16'd1,     "d_min_1");
        run_op(32'd500,                16'd0,     "d_500_0");
        run_op(-32'sd5,                16'd0,     "d_m5_0");
        run_op(32'd0,                  16'd0,     "d_0_0");
        run_op(32'd0,                  16'd9,     "d_0_9");
        run_op(-32'sd32768,            16'd1,     "d_m32768_1");
        run_op(32'd32768,              16'd1,     "d_32768_1");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] b;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 16'($urandom);
                1: b = 16'($urandom_range(1, 255));
                2: begin
                    b = 16'($urandom);
                    a = {{12{a[31]}}, a[19:0]};
                end
                default: b = (i % 7 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            endcase
            run_op(a, b, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] eq;
        logic [16:0] er;
        logic        eo, ez;
        int          w;
        model(32'hFFFF_0123, 16'd300, eq, er, eo, ez);
        @(negedge ap_clk);
        bus.dividend = 32'hFFFF_0123;
        bus.divisor  = 16'd300;
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(posedge ap_clk);
            #1;
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge ap_clk);
            #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf, bus.dz}
                !== {1'b1, 1'b0, eq, er, eo, ez}) begin
                failures++;
                $display("FAIL hold_%0d got vld=%b rdy=%b q=%h r=%h exp q=%h r=%h",
                         c, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, eq, er);
            end
        end
        @(negedge ap_clk);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q_exp[$];
        logic [16:0] r_exp[$];
        logic [1:0]  f_exp[$];
        int          acc_c[$];
        int          out_c[$];
        logic [15:0] eq;
        logic [16:0] er;
        logic        eo, ez;
        logic        took;
        @(negedge ap_clk);
        bus.dividend  = $urandom;
        bus.divisor   = 16'($urandom_range(1, 65535));
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 250 && out_c.size() < 4; c++) begin
            if (c > 0) @(negedge ap_clk);
            took = 1'b0;
            if (bus.in_ready) begin
                model(bus.dividend, bus.divisor, eq, er, eo, ez);
                q_exp.push_back(eq);
                r_exp.push_back(er);
                f_exp.push_back({eo, ez});
                acc_c.push_back(c);
                took = 1'b1;
            end
            if (bus.out_valid && q_exp.size() > 0) begin
                checks++;
                if ({bus.quotient, bus.remainder, bus.ovf, bus.dz}
                    !== {q_exp[0], r_exp[0], f_exp[0]}) begin
                    failures++;
                    $display("FAIL b2b_result got q=%h r=%h exp q=%h r=%h",
                             bus.quotient, bus.remainder, q_exp[0], r_exp[0]);
                end
                void'(q_exp.pop_front());
                void'(r_exp.pop_front());
                void'(f_exp.pop_front());
                out_c.push_back(c);
            end
            @(posedge ap_clk);
            #1;
            if (took) begin
                bus.dividend = $urandom;
                bus.divisor  = 16'($urandom_range(1, 65535));
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 80 && q_exp.size() > 0; c++) begin
            @(negedge ap_clk);
            if (bus.out_valid) begin
                void'(q_exp.pop_front());
                void'(r_exp.pop_front());
                void'(f_exp.pop_front());
            end
        end
        @(negedge ap_clk);
        bus.out_ready = 1'b0;
        checks++;
        if (out_c.size() !== 4 || acc_c.size() < 2) begin
            failures++;
            $display("FAIL b2b_count got results=%0d accepts=%0d exp 4 and >=2",
                     out_c.size(), acc_c.size());
        end else begin
            checks++;
            if (out_c[0] - acc_c[0] !== 34) begin
                failures++;
                $display("FAIL b2b_latency got=%0d exp=34", out_c[0] - acc_c[0]);
            end
            checks++;
            if (acc_c[1] - acc_c[0] !== 35) begin
                failures++;
                $display("FAIL b2b_accept_period got=%0d exp=35", acc_c[1] - acc_c[0]);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (out_c[k] - out_c[k-1] !== 35) begin
                    failures++;
                    $display("FAIL b2b_period_%0d got=%0d exp=35", k, out_c[k] - out_c[k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        @(negedge ap_clk);
        bus.dividend = 32'd123456;
        bus.divisor  = 16'd77;
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder}
            !== {1'b1, 1'b0, 16'h0, 17'h0}) begin
            failures++;
            $display("FAIL midreset_state got rdy=%b vld=%b q=%h r=%h exp 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder);
        end
        ap_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge ap_clk);
            #1;
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_no_output out_valid cycles got=%0d exp=0", seen);
        end
        run_op(-32'sd98765, 16'd321, "after_reset");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = 32'h0;
        bus.divisor   = 16'h0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_div_32s_16u_seq.md
CONV_DIV_32S_16U_SEQ -- requirements
Module: conv_div_32s_16u_seq

Interface
REQ-001 SHALL have parameter LATENCY, default 34, meaning the fixed number of cycles from input handshake to out_valid; it is informational and SHALL NOT be overridden.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 SHALL have port dividend, input, 32 bits: signed two's-complement dividend.
REQ-007 SHALL have port divisor, input, 16 bits: unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port quotient, output, 16 bits: signed, saturated quotient.
REQ-011 SHALL have port remainder, output, 17 bits: signed remainder.
REQ-012 SHALL have port ovf, output, 1 bit: the quotient was saturated because of range overflow.
REQ-013 SHALL have port dz, output, 1 bit: the divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX and DONE; reset state is IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An input handshake occurs when in_valid and in_ready are both 1 at a rising edge; on that edge the block captures dividend, divisor, sign(dividend) and |dividend| as a 32-bit unsigned value (-2^31 maps to 2^31), clears the partial remainder, and moves to CALC.
REQ-017 CALC SHALL run exactly 32 cycles of restoring division, 1 quotient bit per cycle, MSB first, using a 32-bit iteration counter or shift register; it then moves to FIX.
REQ-018 FIX SHALL, in 1 cycle, apply signs and saturation and register all outputs, then move to DONE; out_valid SHALL rise exactly 34 cycles after the accepting edge, independent of operand values.
REQ-019 Division SHALL truncate toward zero; remainder = dividend - q_true*divisor, with the sign of the dividend and |remainder| < divisor, where q_true is the unsaturated quotient.
REQ-020 If q_true > 32767, quotient SHALL be 32767 and ovf 1; if q_true < -32768, quotient SHALL be -32768 and ovf 1; otherwise quotient = q_true and ovf 0.
REQ-021 If divisor = 0: dz = 1, ovf = 0, remainder = 0, and quotient = 32767 for a positive dividend, -32768 for a negative dividend, 0 for a zero dividend; latency is still 34 cycles.
REQ-022 In DONE, quotient, remainder, ovf and dz SHALL hold stable until out_valid and out_ready are both 1 at a rising edge; the FSM then returns to IDLE.
REQ-023 The block SHALL NOT accept a new input on the same edge as the output handshake; in_ready rises the cycle after it.
REQ-024 Input changes while the FSM is not in IDLE SHALL have no effect on the result in progress.

Reset
REQ-025 ap_rst_n = 0 SHALL immediately, without a clock, force IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, ovf = 0, dz = 0, and clear all datapath and counter registers.
REQ-026 A reset asserted during CALC, FIX or DONE SHALL discard the operation; no out_valid SHALL follow after release.
REQ-027 After ap_rst_n deasserts, the block SHALL accept an input on the first rising edge with in_valid = 1.

Verification
REQ-028 dividend = 1000, divisor = 7 -> quotient 142, remainder 6, ovf 0, dz 0, out_valid exactly 34 cycles after acceptance.
REQ-029 dividend = -1000, divisor = 7 -> quotient -142, remainder -6; dividend = 0x7FFFFFFF, divisor = 1 -> quotient 32767, remainder 0, ovf 1.
REQ-030 dividend = -2147483648, divisor = 65535 -> quotient -32768, remainder -32768, ovf 0; dividend = -2147483648, divisor = 1 -> quotient -32768, ovf 1.
REQ-031 dividend = 500, divisor = 0 -> quotient 32767, dz 1, remainder 0; dividend = -5, divisor = 0 -> quotient -32768; dividend = 0, divisor = 0 -> quotient 0, dz 1.
REQ-032 Hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready 0; then out_ready = 1 for 1 cycle -> in_ready = 1 on the next cycle; back-to-back operations with in_valid held high -> one result every 35 cycles.
REQ-033 Pulse ap_rst_n low for 1 ns at cycle 15 of CALC -> out_valid stays 0, in_ready = 1 immediately, and the next operation completes correctly.
